mem_store_unit: RTL

- Write-side companion to the data memory read path.
- Accepts store requests (byte, halfword or word) through a valid/ready handshake and drives the word-organised RAM's synchronous write port.
- Sub-word stores use a read-modify-write sequence that merges bytes into the correct lane of the addressed word.
- Sits between the core's store stage and the RAM; one store in flight at a time.

---
 rtl/mem_store_unit_if.sv | 31 +++
 rtl/mem_store_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_store_unit_if.sv
// Store-unit bus: request handshake from the core, RAM ports and status pulses.
// slave is the store unit's view, master is the core/RAM side.
interface mem_store_unit_if #(
  parameter int RAM_SIZE_LOG = 8,
  parameter int ADDR_W       = RAM_SIZE_LOG + 2
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic [2:0]              req_mode;
  logic [31:0]             req_data;
  logic                    mem_re;
  logic [RAM_SIZE_LOG-1:0] mem_ra;
  logic [31:0]             mem_rd;
  logic                    mem_we;
  logic [RAM_SIZE_LOG-1:0] mem_wa;
  logic [31:0]             mem_wd;
  logic                    done;
  logic                    err;
  logic                    busy;

  modport slave (
    input  req_valid, req_addr, req_mode, req_data, mem_rd,
    output req_ready, mem_re, mem_ra, mem_we, mem_wa, mem_wd, done, err, busy
  );

  modport master (
    output req_valid, req_addr, req_mode, req_data, mem_rd,
    input  req_ready, mem_re, mem_ra, mem_we, mem_wa, mem_wd, done, err, busy
  );
endinterface

// File: rtl/mem_store_unit.sv
// Store unit: byte/half/word stores into a word RAM, sub-word via read-modify-write.
// Define MEM_STORE_MISALIGN_TRAP_EN to reject misaligned half/word stores instead of masking the address.
module mem_store_unit #(
  parameter int RAM_SIZE_LOG = 8,
  parameter int ADDR_W       = RAM_SIZE_LOG + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_store_unit_if.slave  bus
);
  localparam logic [2:0] MODE_B = 3'b000;
  localparam logic [2:0] MODE_H = 3'b001;
  localparam logic [2:0] MODE_W = 3'b010;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, ERR} state_t;

  state_t                  state;
  logic [RAM_SIZE_LOG-1:0] word_addr;
  logic [1:0]              off;
  logic                    is_half;
  logic [15:0]             sdata;
  logic                    re_q, we_q, done_q, err_q;
  logic [RAM_SIZE_LOG-1:0] ra_q, wa_q;
  logic [31:0]             wd_q;

  logic                    legal;
  logic                    misalign;
  logic [1:0]              eff_off;

  always_comb begin
    legal    = (bus.req_mode == MODE_B) || (bus.req_mode == MODE_H) ||
               (bus.req_mode == MODE_W);
    misalign = 1'b0;
`ifdef MEM_STORE_MISALIGN_TRAP_EN
    misalign = ((bus.req_mode == MODE_H) && bus.req_addr[0]) ||
               ((bus.req_mode == MODE_W) && (bus.req_addr[1:0] != 2'b00));
`endif
    // halfwords always land on lane 0 or 2; a trapped build never gets here with addr[0]=1
    eff_off  = (bus.req_mode == MODE_H) ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
  end

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                               input logic [15:0] d,
                                               input logic [1:0]  o,
                                               input logic        half);
    logic [31:0] r;
    r = old;
    if (half) r[{o[1], 4'b0000} +: 16] = d;
    else      r[{o, 3'b000} +: 8]      = d[7:0];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_addr <= '0;
      off       <= '0;
      is_half   <= 1'b0;
      sdata     <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ra_q      <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            word_addr <= bus.req_addr[ADDR_W-1:2];
            off       <= eff_off;
            is_half   <= (bus.req_mode == MODE_H);
            sdata     <= bus.req_data[15:0];
            if (!legal || misalign) begin
              state <= ERR;
              err_q <= 1'b1;
            end else if (bus.req_mode == MODE_W) begin
              state  <= WR;
              we_q   <= 1'b1;
              wa_q   <= bus.req_addr[ADDR_W-1:2];
              wd_q   <= bus.req_data;
              done_q <= 1'b1;
            end else begin
              state <= RD;
              re_q  <= 1'b1;
              ra_q  <= bus.req_addr[ADDR_W-1:2];
            end
          end
        end
        RD:  state <= MRG;
        // mem_rd holds the addressed word during MRG; the merged write is issued on leaving it
        MRG: begin
          state  <= WR;
          we_q   <= 1'b1;
          wa_q   <= word_addr;
          wd_q   <= merge_lanes(bus.mem_rd, sdata, off, is_half);
          done_q <= 1'b1;
        end
        WR:      state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.mem_re    = re_q;
  assign bus.mem_ra    = ra_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wa    = wa_q;
  assign bus.mem_wd    = wd_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
